// File: rtl/vxe_vpu_eu_arb_pkg.sv
// Shared definitions for the VPU store-EU arbiter: FSM state encodings.
package vxe_vpu_eu_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'b00,
        ARB_ISSUE  = 2'b01,
        ARB_SETTLE = 2'b10,
        ARB_WAIT   = 2'b11
    } arb_state_e;

endpackage

// File: rtl/vxe_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping modulo N.
module vxe_rr_pick #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] pick,
    output logic         vld
);

    int idx;

    // Scan farthest-first so the nearest candidate after 'last' is assigned last and wins.
    always_comb begin
        pick = '0;
        vld  = 1'b0;
        idx  = 0;
        for (int i = N; i >= 1; i--) begin
            idx = (int'(last) + i) % N;
            if (req[idx]) begin
                pick = W'(idx);
                vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vxe_vpu_eu_arb.sv
// Round-robin arbiter sharing one VPU store EU among NREQ thread ECUs.
module vxe_vpu_eu_arb
    import vxe_vpu_eu_arb_pkg::*;
#(
    parameter int NREQ = 8,
    parameter int SELW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] i_req_start,
    output logic [NREQ-1:0] o_req_busy,
    output logic            o_eu_start,
    input  logic            i_eu_busy,
    output logic [SELW-1:0] o_eu_sel,
    output logic            o_eu_sel_vld,
    output logic            o_err
);

    arb_state_e      state, state_nxt;
    logic [NREQ-1:0] pend;
    logic [NREQ-1:0] act_mask, live_mask, bad_mask, set_mask, clr_mask;
    logic [SELW-1:0] last, pick;
    logic            pick_vld;
    logic            done;

    vxe_rr_pick #(.N(NREQ), .W(SELW)) u_pick (
        .req  (pend),
        .last (last),
        .pick (pick),
        .vld  (pick_vld)
    );

    assign done = (state == ARB_WAIT) && !i_eu_busy;

    always_comb begin
        act_mask = '0;
        if (o_eu_sel_vld) act_mask[o_eu_sel] = 1'b1;
    end

    // A job finishing this cycle no longer owns its requester, so a fresh start is legal.
    assign live_mask  = done ? '0 : act_mask;
    assign bad_mask   = i_req_start & (pend | live_mask);
    assign set_mask   = i_req_start & ~bad_mask;
    assign clr_mask   = (state == ARB_ISSUE) ? act_mask : '0;
    assign o_req_busy = i_req_start | pend | act_mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ARB_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        o_eu_start = 1'b0;
        case (state)
            ARB_IDLE:   if (pick_vld) state_nxt = ARB_ISSUE;
            ARB_ISSUE: begin
                o_eu_start = 1'b1;
                state_nxt  = ARB_SETTLE;
            end
            ARB_SETTLE: state_nxt = ARB_WAIT;
            ARB_WAIT:   if (!i_eu_busy) state_nxt = ARB_IDLE;
            default:    state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend         <= '0;
            last         <= SELW'(NREQ - 1);
            o_eu_sel     <= '0;
            o_eu_sel_vld <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            pend <= (pend & ~clr_mask) | set_mask;
            if (|bad_mask) o_err <= 1'b1;
            if (state == ARB_IDLE && pick_vld) begin
                o_eu_sel     <= pick;
                o_eu_sel_vld <= 1'b1;
            end
            if (state == ARB_ISSUE) last <= o_eu_sel;
            if (done) o_eu_sel_vld <= 1'b0;
        end
    end

endmodule
